// File: rtl/circuit_vector_sequencer.sv
// -----------------------------------------------------------------------------
// circuit_vector_sequencer
//
// Sweeps a 4-input combinational circuit through an inclusive, optionally
// wrapping range of input vectors. Each vector is driven for one APPLY cycle,
// held for SETTLE cycles, and then the circuit's two outputs are sampled and
// accumulated into population counts (and, optionally, truth tables).
//
// Parameters
//   SETTLE   (1..15) wait cycles between driving a vector and sampling
//
// Ports
//   clk              sole clock, rising edge
//   reset            asynchronous, active-high reset
//   start            sweep request, honoured only in IDLE (abort has priority)
//   abort            synchronous sweep cancel, returns to IDLE next cycle
//   first, last      inclusive vector range, latched when start is accepted
//   e_in, f_in       outputs of the circuit under control
//   a, b, c, d       registered circuit inputs, vector = {a,b,c,d}, a is MSB
//   busy             high in APPLY, SETTLE and SAMPLE
//   done             one-cycle pulse at sweep completion
//   e_count, f_count number of sampled vectors with e_in=1 / f_in=1 (max 16)
//   e_tab, f_tab     captured truth tables, bit index = vector value
//
// Configuration
//   CIRCUIT_TRUTH_TABLE_EN  when defined, SAMPLE records e_in/f_in into
//                           e_tab/f_tab; otherwise both ports are tied to 0
//                           and no table storage exists.
// -----------------------------------------------------------------------------
module circuit_vector_sequencer #(
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [3:0]  first,
  input  logic [3:0]  last,
  input  logic        e_in,
  input  logic        f_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [4:0]  e_count,
  output logic [4:0]  f_count,
  output logic [15:0] e_tab,
  output logic [15:0] f_tab
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_APPLY  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0] state;
  logic [3:0] vec;       // vector currently being swept
  logic [3:0] last_vec;  // inclusive end of the sweep
  logic [3:0] wait_cnt;  // remaining settle cycles
  logic [3:0] vec_out;   // registered drive onto {a,b,c,d}

  // A start is taken only from IDLE and only when abort is not also asserted.
  logic accept;
  // A vector's result is committed in SAMPLE unless the sweep is being aborted.
  logic sample_en;

  assign accept    = (state == S_IDLE) && start && !abort;
  assign sample_en = (state == S_SAMPLE) && !abort;

  assign {a, b, c, d} = vec_out;
  assign busy = (state == S_APPLY) || (state == S_SETTLE) || (state == S_SAMPLE);
  assign done = (state == S_DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      vec      <= 4'd0;
      last_vec <= 4'd0;
      wait_cnt <= 4'd0;
      vec_out  <= 4'd0;
      e_count  <= 5'd0;
      f_count  <= 5'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            vec      <= first;
            last_vec <= last;
            vec_out  <= first;
            e_count  <= 5'd0;
            f_count  <= 5'd0;
            state    <= S_APPLY;
          end
        end

        S_APPLY: begin
          if (abort) begin
            state <= S_IDLE;
          end else begin
            wait_cnt <= 4'(SETTLE);
            state    <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (abort) begin
            state <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
            if (wait_cnt == 4'd1) state <= S_SAMPLE;
          end
        end

        S_SAMPLE: begin
          if (abort) begin
            state <= S_IDLE;
          end else begin
            // At most 16 vectors per sweep, so a 5-bit count cannot wrap.
            e_count <= e_count + {4'd0, e_in};
            f_count <= f_count + {4'd0, f_in};
            if (vec == last_vec) begin
              state <= S_DONE;
            end else begin
              // 4-bit increment wraps 15 -> 0 for ranges with first > last.
              vec     <= vec + 4'd1;
              vec_out <= vec + 4'd1;
              state   <= S_APPLY;
            end
          end
        end

        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CIRCUIT_TRUTH_TABLE_EN
  logic [15:0] e_tab_q;
  logic [15:0] f_tab_q;

  // NOTE: the tables are plain flops with async reset rather than a RAM, so
  // clearing them on reset and on every accepted start costs nothing extra.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_tab_q <= 16'd0;
      f_tab_q <= 16'd0;
    end else if (accept) begin
      e_tab_q <= 16'd0;
      f_tab_q <= 16'd0;
    end else if (sample_en) begin
      e_tab_q[vec] <= e_in;
      f_tab_q[vec] <= f_in;
    end
  end

  assign e_tab = e_tab_q;
  assign f_tab = f_tab_q;
`else
  // Tables disabled: ports stay for interface compatibility, tied low.
  assign e_tab = 16'd0;
  assign f_tab = 16'd0;
`endif

endmodule

// File: tb/tb_circuit_vector_sequencer.sv
// -----------------------------------------------------------------------------
// tb_circuit_vector_sequencer
//
// Drives circuit_vector_sequencer (SETTLE=2) with the circuit e = a^b,
// f = e & d. A behavioural model derives every output from the elapsed cycle
// count within a sweep; a compare process checks all outputs against it on
// each falling edge. Directed scenarios add literal expectations, followed by
// a randomized phase.
// -----------------------------------------------------------------------------
module tb_circuit_vector_sequencer;

  localparam int S = 2;
  localparam int P = S + 2;  // cycles per vector

`ifdef CIRCUIT_TRUTH_TABLE_EN
  localparam logic [15:0] ET_FULL = 16'h0FF0;
  localparam logic [15:0] FT_FULL = 16'h0AA0;
  localparam logic [15:0] FT_FIVE = 16'h0020;
`else
  localparam logic [15:0] ET_FULL = 16'h0000;
  localparam logic [15:0] FT_FULL = 16'h0000;
  localparam logic [15:0] FT_FIVE = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [3:0]  first;
  logic [3:0]  last;
  logic        e_in;
  logic        f_in;
  logic        a, b, c, d;
  logic        busy;
  logic        done;
  logic [4:0]  e_count;
  logic [4:0]  f_count;
  logic [15:0] e_tab;
  logic [15:0] f_tab;

  int n_vec = 0;
  int n_mis = 0;

  circuit_vector_sequencer #(.SETTLE(S)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .first   (first),
    .last    (last),
    .e_in    (e_in),
    .f_in    (f_in),
    .a       (a),
    .b       (b),
    .c       (c),
    .d       (d),
    .busy    (busy),
    .done    (done),
    .e_count (e_count),
    .f_count (f_count),
    .e_tab   (e_tab),
    .f_tab   (f_tab)
  );

  always #5 clk = ~clk;

  // Circuit under control.
  assign e_in = a ^ b;
  assign f_in = e_in & d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: a sweep of m_n vectors starting at m_first occupies
  // m_n*P cycles; cycle m_t of the sweep drives vector m_first + m_t/P, samples
  // it on the last cycle of each P-cycle slot, and cycle m_n*P is the done pulse.
  // ---------------------------------------------------------------------------
  logic        m_active;
  int          m_t;
  int          m_n;
  logic [3:0]  m_first;
  logic [3:0]  m_abcd;
  logic [4:0]  m_ec;
  logic [4:0]  m_fc;
  logic [15:0] m_et;
  logic [15:0] m_ft;

  always @(posedge clk or posedge reset) begin : model
    automatic int  slot;
    automatic logic e;
    automatic logic f;
    if (reset) begin
      m_active <= 1'b0;
      m_t      <= 0;
      m_n      <= 0;
      m_first  <= 4'd0;
      m_abcd   <= 4'd0;
      m_ec     <= 5'd0;
      m_fc     <= 5'd0;
      m_et     <= 16'd0;
      m_ft     <= 16'd0;
    end else if (!m_active) begin
      if (start && !abort) begin
        m_active <= 1'b1;
        m_t      <= 0;
        m_first  <= first;
        m_n      <= (int'(last) - int'(first) + 16) % 16 + 1;
        m_abcd   <= first;
        m_ec     <= 5'd0;
        m_fc     <= 5'd0;
        m_et     <= 16'd0;
        m_ft     <= 16'd0;
      end
    end else if (m_t == m_n * P || abort) begin
      m_active <= 1'b0;
    end else begin
      if (m_t % P == P - 1) begin
        slot = m_t / P;
        e = m_abcd[3] ^ m_abcd[2];
        f = e & m_abcd[0];
        m_ec <= m_ec + 5'(e);
        m_fc <= m_fc + 5'(f);
`ifdef CIRCUIT_TRUTH_TABLE_EN
        m_et[m_abcd] <= e;
        m_ft[m_abcd] <= f;
`endif
        if (slot < m_n - 1) m_abcd <= m_first + 4'(slot + 1);
      end
      m_t <= m_t + 1;
    end
  end

  always @(negedge clk) begin
    check("abcd",    {28'd0, a, b, c, d}, {28'd0, m_abcd});
    check("busy",    {31'd0, busy}, {31'd0, (m_active && m_t != m_n * P)});
    check("done",    {31'd0, done}, {31'd0, (m_active && m_t == m_n * P)});
    check("e_count", {27'd0, e_count}, {27'd0, m_ec});
    check("f_count", {27'd0, f_count}, {27'd0, m_fc});
    check("e_tab",   {16'd0, e_tab}, {16'd0, m_et});
    check("f_tab",   {16'd0, f_tab}, {16'd0, m_ft});
  end

  // ---------------------------------------------------------------------------
  // Directed helpers
  // ---------------------------------------------------------------------------
  logic [3:0] seen[$];  // vectors observed in APPLY cycles of the last sweep

  // Call at a falling edge with the DUT idle. Returns cycles from the start
  // cycle to the done pulse and the number of busy cycles seen.
  task automatic run_sweep(input logic [3:0] f, input logic [3:0] l, input bit repulse,
                           output int cyc, output int busy_cyc, output bit got_done);
    first    = f;
    last     = l;
    start    = 1'b1;
    cyc      = 0;
    busy_cyc = 0;
    got_done = 1'b0;
    seen.delete();
    for (int i = 0; i < 400 && !got_done; i++) begin
      @(negedge clk);
      cyc++;
      start = repulse && (cyc % 7 == 3);
      if (busy) busy_cyc++;
      if (busy && (cyc % P == 1)) seen.push_back({a, b, c, d});
      if (done) got_done = 1'b1;
    end
    start = 1'b0;
    check("sweep_done_seen", {31'd0, got_done}, 32'd1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    int  cyc;
    int  bcyc;
    bit  got;
    bit  saw_done;

    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    first = 4'd0;
    last  = 4'd0;
    repeat (3) @(negedge clk);
    check("reset_abcd",  {28'd0, a, b, c, d}, 32'd0);
    check("reset_busy",  {31'd0, busy}, 32'd0);
    check("reset_count", {27'd0, e_count}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Full sweep 0..15.
    run_sweep(4'd0, 4'd15, 1'b0, cyc, bcyc, got);
    check("full_latency", cyc, 32'd65);
    check("full_busy",    bcyc, 32'd64);
    check("full_e_count", {27'd0, e_count}, 32'd8);
    check("full_f_count", {27'd0, f_count}, 32'd4);
    check("full_e_tab",   {16'd0, e_tab}, {16'd0, ET_FULL});
    check("full_f_tab",   {16'd0, f_tab}, {16'd0, FT_FULL});
    repeat (2) @(negedge clk);

    // Wrapping range 14..1.
    run_sweep(4'd14, 4'd1, 1'b0, cyc, bcyc, got);
    check("wrap_busy", bcyc, 32'd16);
    check("wrap_len",  seen.size(), 32'd4);
    if (seen.size() == 4) begin
      check("wrap_v0", {28'd0, seen[0]}, 32'd14);
      check("wrap_v1", {28'd0, seen[1]}, 32'd15);
      check("wrap_v2", {28'd0, seen[2]}, 32'd0);
      check("wrap_v3", {28'd0, seen[3]}, 32'd1);
    end
    check("wrap_e_count", {27'd0, e_count}, 32'd0);
    check("wrap_f_count", {27'd0, f_count}, 32'd0);
    @(negedge clk);

    // Single vector 5..5.
    run_sweep(4'd5, 4'd5, 1'b0, cyc, bcyc, got);
    check("one_latency", cyc, 32'd5);
    check("one_len", seen.size(), 32'd1);
    if (seen.size() == 1) check("one_vec", {28'd0, seen[0]}, 32'd5);
    check("one_e_count", {27'd0, e_count}, 32'd1);
    check("one_f_count", {27'd0, f_count}, 32'd1);
    check("one_f_tab",   {16'd0, f_tab}, {16'd0, FT_FIVE});
    @(negedge clk);

    // Abort during the third APPLY (cycle 9 after the start cycle).
    first = 4'd0;
    last  = 4'd15;
    start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("abort_in_apply3", {28'd0, a, b, c, d}, 32'd2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    saw_done = done;
    repeat (10) begin
      @(negedge clk);
      saw_done |= done;
    end
    check("abort_no_done", {31'd0, saw_done}, 32'd0);
    check("abort_e_count", {27'd0, e_count}, 32'd0);
    check("abort_f_count", {27'd0, f_count}, 32'd0);

    // Async reset during SETTLE of vector 5 in a 4..15 sweep.
    first = 4'd4;
    last  = 4'd15;
    start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_reset_abcd",  {28'd0, a, b, c, d}, 32'd5);
    check("pre_reset_count", {27'd0, e_count}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_abcd",  {28'd0, a, b, c, d}, 32'd0);
    check("async_busy",  {31'd0, busy}, 32'd0);
    check("async_count", {27'd0, e_count}, 32'd0);
    check("async_e_tab", {16'd0, e_tab}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_sweep(4'd0, 4'd15, 1'b0, cyc, bcyc, got);
    check("post_reset_latency", cyc, 32'd65);
    check("post_reset_e_count", {27'd0, e_count}, 32'd8);
    @(negedge clk);

    // start+abort together in IDLE, then start re-pulsed while busy.
    first = 4'd3;
    last  = 4'd3;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", {31'd0, busy}, 32'd0);
    run_sweep(4'd0, 4'd15, 1'b1, cyc, bcyc, got);
    check("repulse_latency", cyc, 32'd65);
    check("repulse_e_count", {27'd0, e_count}, 32'd8);
    check("repulse_f_count", {27'd0, f_count}, 32'd4);
    check("repulse_e_tab",   {16'd0, e_tab}, {16'd0, ET_FULL});
    check("repulse_f_tab",   {16'd0, f_tab}, {16'd0, FT_FULL});
    @(negedge clk);

    // Randomized phase, checked every cycle by the compare process.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 63) == 0);
      first = 4'($urandom_range(0, 15));
      last  = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (80) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/circuit_vector_sequencer.md
CIRCUIT_VECTOR_SEQUENCER -- requirements
Module: circuit_vector_sequencer

Interface
REQ-001 SHALL have parameter SETTLE, default 2, range 1..15: wait cycles between driving a vector and sampling the circuit outputs.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: request a sweep; sampled only in IDLE.
REQ-005 SHALL have port abort, input, 1: synchronous sweep cancel.
REQ-006 SHALL have ports first and last, input, 4 each: inclusive vector range, sampled when start is accepted.
REQ-007 SHALL have ports e_in and f_in, input, 1 each: outputs of the 4-input circuit under control.
REQ-008 SHALL have ports a, b, c, d, output, 1 each, registered: circuit inputs, vector = {a,b,c,d} with a as MSB.
REQ-009 SHALL have port busy, output, 1: high in any state other than IDLE and DONE.
REQ-010 SHALL have port done, output, 1: one-cycle pulse at sweep completion.
REQ-011 SHALL have ports e_count and f_count, output, 5 each: number of sampled vectors with e_in=1 and f_in=1.
REQ-012 SHALL have ports e_tab and f_tab, output, 16 each: captured truth tables, bit index = vector value.

Function
REQ-013 SHALL implement states IDLE, APPLY, SETTLE, SAMPLE and DONE.
REQ-014 IDLE with start=1 and abort=0 SHALL latch first and last into vec/end registers, clear counts and tables, and enter APPLY.
REQ-015 APPLY SHALL drive {a,b,c,d}=vec for one cycle, then enter SETTLE with the wait counter loaded to SETTLE.
REQ-016 SETTLE SHALL decrement the wait counter and enter SAMPLE when it reaches 1.
REQ-017 SAMPLE SHALL add e_in to e_count and f_in to f_count.
REQ-018 From SAMPLE: if vec==end, enter DONE; otherwise vec <= vec+1 mod 16 and enter APPLY.
REQ-019 Per-vector cost SHALL be SETTLE+2 cycles; a full 16-vector sweep with SETTLE=2 SHALL take 64 cycles from the first APPLY to DONE.
REQ-020 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-021 Range wrap: first>last SHALL sweep through 15 to 0 (e.g. 14,15,0,1); first==last SHALL sweep exactly one vector.
REQ-022 abort=1 in any non-IDLE state SHALL return to IDLE next cycle with no done pulse; counts and tables hold their partial values.
REQ-023 abort and start asserted together in IDLE: abort wins and start is ignored.
REQ-024 start while busy SHALL be ignored (no queuing).
REQ-025 a..d, counts and tables SHALL hold their values in IDLE until the next accepted start.
REQ-026 Counts SHALL not overflow: maximum value is 16, which fits in 5 bits.

Reset
REQ-027 reset=1 SHALL immediately force state IDLE; a=b=c=d=0; busy=0; done=0; e_count=f_count=0; e_tab=f_tab=0; vec=0; wait counter=0.
REQ-028 Reset asserted mid-sweep SHALL discard the sweep, with no done pulse.

Configuration
REQ-029 Macro CIRCUIT_TRUTH_TABLE_EN, when defined: SAMPLE SHALL write e_tab[vec]<=e_in and f_tab[vec]<=f_in; bits for unvisited vectors stay 0.
REQ-030 Without CIRCUIT_TRUTH_TABLE_EN: e_tab and f_tab ports SHALL remain present and constant 0, with no table registers; counts are unaffected.

Verification
Bench model: e_in = a^b, f_in = e_in&d, combinational. SETTLE=2.
REQ-031 first=0, last=15, start pulse -> done 65 cycles after start accepted; e_count=8, f_count=4; e_tab=16'h0FF0, f_tab=16'h0AA0 (macro on) or 0 (macro off).
REQ-032 first=14, last=1 -> vectors applied in order 14,15,0,1; e_count=0, f_count=0; busy high for 16 cycles.
REQ-033 first=last=5 -> one vector {0,1,0,1}; e_count=1, f_count=1; f_tab=16'h0020.
REQ-034 abort asserted in the 3rd APPLY of a 0..15 sweep -> IDLE next cycle, no done; e_count=0, f_count=0 (vectors 0,1 sampled).
REQ-035 Async reset asserted mid-SETTLE -> outputs zero within the same cycle, with no clock edge needed; a later start runs normally.
REQ-036 start re-pulsed while busy, plus start and abort together in IDLE -> both ignored; sweep results match REQ-031.
